// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequences a BYTES-wide operation through an external 8-bit combinational ALU
module alu_seq #(
   parameter int BYTES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [2:0]           op,
   input  logic [8*BYTES-1:0]   a_in,
   input  logic [8*BYTES-1:0]   b_in,
   input  logic                 c_in,
   output logic                 done_valid,
   input  logic                 done_ready,
   output logic [8*BYTES-1:0]   result,
   output logic                 c_out_final,
   output logic                 busy,
   output logic [79:0]          alu_oper,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic                 alu_c_in,
   input  logic [7:0]           alu_sum,
   input  logic                 alu_c_out
);

   localparam int               IDX_W    = $clog2(BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   // Opcode strings understood by the ALU; "and" is its addition encoding.
   localparam logic [79:0] STR_ADD   = "and";
   localparam logic [79:0] STR_SUB   = "subtract";
   localparam logic [79:0] STR_SUBA  = "subtract_a";
   localparam logic [79:0] STR_OR    = "or_ab";
   localparam logic [79:0] STR_AND   = "and_ab";
   localparam logic [79:0] STR_NAB   = "not_ab";
   localparam logic [79:0] STR_XOR   = "exor";
   localparam logic [79:0] STR_XNOR  = "exnor";

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [8*BYTES-1:0]   a_q, a_d;
   logic [8*BYTES-1:0]   b_q, b_d;
   logic [8*BYTES-1:0]   result_q, result_d;
   logic                 cin_q, cin_d;
   logic                 carry_q, carry_d;
   logic                 cout_q, cout_d;
   logic [IDX_W-1:0]     idx_q, idx_d;

   logic [IDX_W+2:0]     bit_base;
   logic                 accept;
   logic                 last_byte;
   logic                 logic_op;

   assign bit_base  = {idx_q, 3'b000};
   assign accept    = start_valid && (state_q == IDLE);
   assign last_byte = (idx_q == LAST_IDX);
   assign logic_op  = (op_q >= 3'd3);

   assign result      = result_q;
   assign c_out_final = cout_q;

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         idx_q    <= idx_d;
         result_q <= result_d;
      end
   end

   // Next-state logic: accept, step through the bytes, then hold until consumed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last_byte) state_d = DONE;
         DONE:    if (done_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: latch the request, then collect one ALU byte and its carry per cycle.
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cin_d    = cin_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      idx_d    = idx_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = op;
               a_d     = a_in;
               b_d     = b_in;
               cin_d   = c_in;
               carry_d = c_in;
               idx_d   = '0;
            end
         end
         RUN: begin
            result_d[bit_base +: 8] = alu_sum;
            carry_d                 = alu_c_out;
            idx_d                   = idx_q + 1'b1;
            if (last_byte) begin
               // The ALU's carry is meaningless for bitwise ops, so never report it.
               cout_d = logic_op ? 1'b0 : alu_c_out;
            end
         end
         default: ;
      endcase
   end

   // Outputs: handshake flags from the state, ALU drive only while running.
   always_comb begin
      start_ready = (state_q == IDLE);
      busy        = (state_q == RUN);
      done_valid  = (state_q == DONE);
      alu_oper    = STR_ADD;
      alu_a       = 8'h00;
      alu_b       = 8'h00;
      alu_c_in    = 1'b0;
      if (state_q == RUN) begin
         alu_a = a_q[bit_base +: 8];
         alu_b = b_q[bit_base +: 8];
         case (op_q)
            3'd0: begin
               alu_oper = STR_ADD;
               alu_c_in = carry_q;
            end
            3'd1: begin
               alu_oper = STR_SUB;
               alu_c_in = carry_q;
            end
            3'd2: begin
               // The ALU inverts its carry-in for subtract_a, so feed back the
               // complement of the chained carry after the first byte.
               alu_oper = STR_SUBA;
               alu_c_in = (idx_q == '0) ? cin_q : ~carry_q;
            end
            3'd3:    alu_oper = STR_OR;
            3'd4:    alu_oper = STR_AND;
            3'd5:    alu_oper = STR_NAB;
            3'd6:    alu_oper = STR_XOR;
            default: alu_oper = STR_XNOR;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq with an 8-bit ALU model
module tb_alu_seq;

   localparam int BYTES = 4;
   localparam int W     = 8 * BYTES;

   localparam logic [79:0] S_ADD  = "and";
   localparam logic [79:0] S_SUB  = "subtract";
   localparam logic [79:0] S_SUBA = "subtract_a";
   localparam logic [79:0] S_OR   = "or_ab";
   localparam logic [79:0] S_AND  = "and_ab";
   localparam logic [79:0] S_NAB  = "not_ab";
   localparam logic [79:0] S_XOR  = "exor";
   localparam logic [79:0] S_XNOR = "exnor";

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_valid;
   logic          start_ready;
   logic [2:0]    op;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          c_in;
   logic          done_valid;
   logic          done_ready;
   logic [W-1:0]  result;
   logic          c_out_final;
   logic          busy;
   logic [79:0]   alu_oper;
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic          alu_c_in;
   logic [7:0]    alu_sum;
   logic          alu_c_out;
   logic [8:0]    alu_t;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_seq #(.BYTES(BYTES)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .op(op), .a_in(a_in), .b_in(b_in), .c_in(c_in),
      .done_valid(done_valid), .done_ready(done_ready),
      .result(result), .c_out_final(c_out_final), .busy(busy),
      .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
      .alu_sum(alu_sum), .alu_c_out(alu_c_out)
   );

   // External 8-bit ALU; logic ops raise c_out and unknown strings give junk.
   always_comb begin
      alu_t = 9'h1EE;
      case (alu_oper)
         S_ADD:  alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
         S_SUB:  alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_c_in};
         S_SUBA: alu_t = {1'b0, alu_b} + {1'b0, ~alu_a} + {8'd0, ~alu_c_in};
         S_OR:   alu_t = {1'b1, alu_a | alu_b};
         S_AND:  alu_t = {1'b1, alu_a & alu_b};
         S_NAB:  alu_t = {1'b1, ~alu_a & alu_b};
         S_XOR:  alu_t = {1'b1, alu_a ^ alu_b};
         S_XNOR: alu_t = {1'b1, ~(alu_a ^ alu_b)};
         default: alu_t = 9'h1EE;
      endcase
   end
   assign alu_sum   = alu_t[7:0];
   assign alu_c_out = alu_t[8];

   // Whole-word reference: plain wide arithmetic on the full operands.
   function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic ci,
                                     output logic [W-1:0] r, output logic co);
      logic [63:0] x, y, c, t;
      x = {32'd0, a};
      y = {32'd0, b};
      c = {63'd0, ci};
      t = 64'd0;
      co = 1'b0;
      case (o)
         3'd0: begin t = x + y + c; r = t[W-1:0]; co = t[W]; end
         3'd1: begin t = x - y - (64'd1 - c); r = t[W-1:0]; co = (x >= y + (64'd1 - c)); end
         3'd2: begin t = y - x - c; r = t[W-1:0]; co = (y >= x + c); end
         3'd3: r = a | b;
         3'd4: r = a & b;
         3'd5: r = ~a & b;
         3'd6: r = a ^ b;
         default: r = ~(a ^ b);
      endcase
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return W'(32'h000000FF << (8 * $urandom_range(0, BYTES - 1)));
         default: return W'($urandom);
      endcase
   endfunction

   // Runs one request from an idle negedge; scrambles inputs after the accept edge.
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, output logic [W-1:0] res, output logic co,
                        output int lat, output int busy_cyc);
      int guard;
      guard = 0;
      while (!start_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      op = o; a_in = a; b_in = b; c_in = ci; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      op = 3'($urandom); a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
      lat = 1;
      busy_cyc = 0;
      while (!done_valid && lat < 40) begin
         if (busy) busy_cyc++;
         @(negedge clk);
         lat++;
      end
      res = result;
      co  = c_out_final;
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_vec++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
      n_vec++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
      n_vec++; if (c_out_final !== 1'b0) begin n_err++; $display("FAIL reset_c_out_final: got %b want 0", c_out_final); end
      n_vec++; if (alu_oper !== S_ADD) begin n_err++; $display("FAIL reset_alu_oper: got %h want %h", alu_oper, S_ADD); end
      n_vec++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin n_err++; $display("FAIL reset_alu_ab: got %h/%h want 00/00", alu_a, alu_b); end
      n_vec++; if (alu_c_in !== 1'b0) begin n_err++; $display("FAIL reset_alu_c_in: got %b want 0", alu_c_in); end
   endtask

   task automatic test_add();
      logic [W-1:0] r; logic co; int lat, bc;
      do_op(3'd0, 32'h000000FF, 32'h00000001, 1'b0, r, co, lat, bc);
      n_vec++; if (r !== 32'h00000100) begin n_err++; $display("FAIL add_carry_result: got %h want 00000100", r); end
      n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL add_carry_cout: got %b want 0", co); end
      n_vec++; if (lat !== BYTES + 1) begin n_err++; $display("FAIL add_latency: got %0d want %0d", lat, BYTES + 1); end
      n_vec++; if (bc !== BYTES) begin n_err++; $display("FAIL add_busy_cycles: got %0d want %0d", bc, BYTES); end
      do_op(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, r, co, lat, bc);
      n_vec++; if (r !== 32'h00000000) begin n_err++; $display("FAIL add_wrap_result: got %h want 00000000", r); end
      n_vec++; if (co !== 1'b1) begin n_err++; $display("FAIL add_wrap_cout: got %b want 1", co); end
   endtask

   task automatic test_subtract();
      logic [W-1:0] r; logic co; int lat, bc;
      do_op(3'd1, 32'h00000100, 32'h00000001, 1'b1, r, co, lat, bc);
      n_vec++; if (r !== 32'h000000FF) begin n_err++; $display("FAIL sub_result: got %h want 000000FF", r); end
      n_vec++; if (co !== 1'b1) begin n_err++; $display("FAIL sub_cout: got %b want 1", co); end
      do_op(3'd1, 32'h00000000, 32'h00000001, 1'b1, r, co, lat, bc);
      n_vec++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sub_borrow_result: got %h want FFFFFFFF", r); end
      n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL sub_borrow_cout: got %b want 0", co); end
      do_op(3'd2, 32'h00000001, 32'h00000100, 1'b0, r, co, lat, bc);
      n_vec++; if (r !== 32'h000000FF) begin n_err++; $display("FAIL suba_result: got %h want 000000FF", r); end
      do_op(3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, r, co, lat, bc);
      n_vec++; if (r !== 32'h0FF00FF0) begin n_err++; $display("FAIL xor_result: got %h want 0FF00FF0", r); end
      n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL xor_cout: got %b want 0", co); end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, r, er; logic [2:0] o; logic ci, co, eco; int lat, bc;
      for (int i = 0; i < 80; i++) begin
         o  = 3'(i % 8);
         a  = pick_operand();
         b  = pick_operand();
         ci = 1'($urandom);
         ref_model(o, a, b, ci, er, eco);
         do_op(o, a, b, ci, r, co, lat, bc);
         n_vec++; if (r !== er) begin n_err++; $display("FAIL rand_result op=%0d a=%h b=%h ci=%b: got %h want %h", o, a, b, ci, r, er); end
         n_vec++; if (co !== eco) begin n_err++; $display("FAIL rand_cout op=%0d a=%h b=%h ci=%b: got %b want %b", o, a, b, ci, co, eco); end
         n_vec++; if (lat !== BYTES + 1) begin n_err++; $display("FAIL rand_latency op=%0d: got %0d want %0d", o, lat, BYTES + 1); end
      end
   endtask

   task automatic test_back_pressure();
      logic [W-1:0] a1, b1, a2, b2, r1, r2; logic c1, c2, co1, co2; int k;
      a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
      a2 = W'($urandom); b2 = W'($urandom); c2 = 1'b1;
      ref_model(3'd0, a1, b1, c1, r1, co1);
      ref_model(3'd1, a2, b2, c2, r2, co2);
      op = 3'd0; a_in = a1; b_in = b1; c_in = c1; start_valid = 1'b1; done_ready = 1'b0;
      @(negedge clk);
      op = 3'd1; a_in = a2; b_in = b2; c_in = c2;
      k = 0;
      while (!done_valid && k < 40) begin @(negedge clk); k++; end
      for (int i = 0; i < 10; i++) begin
         n_vec++; if (done_valid !== 1'b1) begin n_err++; $display("FAIL bp_done_valid cyc %0d: got %b want 1", i, done_valid); end
         n_vec++; if (result !== r1) begin n_err++; $display("FAIL bp_result cyc %0d: got %h want %h", i, result, r1); end
         n_vec++; if (c_out_final !== co1) begin n_err++; $display("FAIL bp_cout cyc %0d: got %b want %b", i, c_out_final, co1); end
         n_vec++; if (start_ready !== 1'b0) begin n_err++; $display("FAIL bp_start_ready cyc %0d: got %b want 0", i, start_ready); end
         @(negedge clk);
      end
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      n_vec++; if (start_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_back_idle: got ready=%b busy=%b want 1/0", start_ready, busy); end
      @(negedge clk);
      start_valid = 1'b0;
      n_vec++; if (busy !== 1'b1 || start_ready !== 1'b0) begin n_err++; $display("FAIL bp_pending_accept: got busy=%b ready=%b want 1/0", busy, start_ready); end
      k = 0;
      while (!done_valid && k < 40) begin @(negedge clk); k++; end
      n_vec++; if (result !== r2) begin n_err++; $display("FAIL bp_second_result: got %h want %h", result, r2); end
      n_vec++; if (c_out_final !== co2) begin n_err++; $display("FAIL bp_second_cout: got %b want %b", c_out_final, co2); end
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, er; logic eco; int seen, cyc; int t[3];
      a = W'($urandom); b = W'($urandom);
      ref_model(3'd0, a, b, 1'b1, er, eco);
      op = 3'd0; a_in = a; b_in = b; c_in = 1'b1;
      start_valid = 1'b1; done_ready = 1'b1;
      seen = 0; cyc = 0; t = '{0, 0, 0};
      while (seen < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done_valid) begin
            n_vec++; if (result !== er || c_out_final !== eco) begin n_err++; $display("FAIL b2b_result %0d: got %h/%b want %h/%b", seen, result, c_out_final, er, eco); end
            t[seen] = cyc;
            seen++;
            if (seen == 3) start_valid = 1'b0;
         end
      end
      start_valid = 1'b0;
      @(negedge clk);
      done_ready = 1'b0;
      n_vec++; if (seen !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", seen); end
      n_vec++; if (t[1] - t[0] !== BYTES + 2) begin n_err++; $display("FAIL b2b_spacing1: got %0d want %0d", t[1] - t[0], BYTES + 2); end
      n_vec++; if (t[2] - t[1] !== BYTES + 2) begin n_err++; $display("FAIL b2b_spacing2: got %0d want %0d", t[2] - t[1], BYTES + 2); end
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] a, b, r, er; logic co, eco; int lat, bc;
      op = 3'd0; a_in = 32'h12345678; b_in = 32'h9ABCDEF0; c_in = 1'b1; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL midrst_start_ready: got %b want 1", start_ready); end
      n_vec++; if (busy !== 1'b0 || done_valid !== 1'b0) begin n_err++; $display("FAIL midrst_busy_done: got %b/%b want 0/0", busy, done_valid); end
      n_vec++; if (result !== '0) begin n_err++; $display("FAIL midrst_result: got %h want 0", result); end
      n_vec++; if (c_out_final !== 1'b0) begin n_err++; $display("FAIL midrst_cout: got %b want 0", c_out_final); end
      rst_n = 1'b1;
      a = W'($urandom); b = W'($urandom);
      ref_model(3'd0, a, b, 1'b0, er, eco);
      do_op(3'd0, a, b, 1'b0, r, co, lat, bc);
      n_vec++; if (r !== er || co !== eco) begin n_err++; $display("FAIL midrst_fresh_add: got %h/%b want %h/%b", r, co, er, eco); end
   endtask

   initial begin
      rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
      op = 3'd0; a_in = '0; b_in = '0; c_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_add();
      test_subtract();
      test_random();
      test_back_pressure();
      test_back_to_back();
      // Leave a non-zero carry flag behind so the reset check below is meaningful.
      begin
         logic [W-1:0] r; logic co; int lat, bc;
         do_op(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, r, co, lat, bc);
      end
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
